// File: rtl/bp_snd_pkg.sv
// Shared types and widths for the Blue Print main-CPU/sound-CPU mailbox.
//   CMD_W      : command/response byte width
//   IRQ_CNT_W  : width of the sound-CPU IRQ period counter
//   NMI_CNT_W  : width of the NMI pulse-length counter
//   nmi_state_t: NMI handshake states
package bp_snd_pkg;

    localparam int unsigned CMD_W     = 8;
    localparam int unsigned IRQ_CNT_W = 16;
    localparam int unsigned NMI_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        WAIT_RD = 2'd2
    } nmi_state_t;

endpackage

// File: rtl/bp_cen_period_timer.sv
// Counts enabled ticks from 0 to PERIOD-1 and flags the wrap.
//   clk    : system clock
//   reset  : synchronous, active-high
//   tick   : advance enable (clock enable already qualified by pause)
//   wrap_c : high in the cycle the counter wraps from PERIOD-1 to 0
module bp_cen_period_timer
    import bp_snd_pkg::*;
#(
    parameter int unsigned PERIOD = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    output logic wrap_c
);

    localparam logic [IRQ_CNT_W-1:0] LAST = IRQ_CNT_W'(PERIOD - 1);

    logic [IRQ_CNT_W-1:0] count;

    assign wrap_c = tick && (count == LAST);

    // Period counter
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (wrap_c) begin
            count <= '0;
        end else if (tick) begin
            count <= count + IRQ_CNT_W'(1);
        end
    end

endmodule

// File: rtl/bp_sound_mailbox_ctrl.sv
// Main-CPU to sound-CPU mailbox: command latch with NMI handshake,
// response latch, and the sound CPU's periodic IRQ scheduler.
// All timing is counted in cen_snd ticks so underclocking is transparent.
//   clk_49m, reset               : system clock, synchronous active-high reset
//   cen_snd, pause               : sound-CPU clock enable; pause freezes counters
//   main_cmd_wr/main_cmd_din     : main CPU command write
//   snd_cmd_rd/snd_cmd_dout      : sound CPU command read
//   cmd_pending, cmd_overrun     : command status (overrun is sticky)
//   snd_nmi_n, snd_irq_n         : sound-CPU interrupts, active low
//   snd_irq_ack                  : sound-CPU interrupt acknowledge
//   snd_rsp_wr/snd_rsp_din       : sound CPU response write
//   main_rsp_rd/main_rsp_dout    : main CPU response read
//   rsp_valid                    : response written and not yet read
module bp_sound_mailbox_ctrl
    import bp_snd_pkg::*;
#(
    parameter int unsigned IRQ_PERIOD = 4096,
    parameter int unsigned NMI_CYCLES = 32
) (
    input  logic             clk_49m,
    input  logic             reset,
    input  logic             cen_snd,
    input  logic             pause,
    input  logic             main_cmd_wr,
    input  logic [CMD_W-1:0] main_cmd_din,
    input  logic             snd_cmd_rd,
    output logic [CMD_W-1:0] snd_cmd_dout,
    output logic             cmd_pending,
    output logic             cmd_overrun,
    output logic             snd_nmi_n,
    output logic             snd_irq_n,
    input  logic             snd_irq_ack,
    input  logic             snd_rsp_wr,
    input  logic [CMD_W-1:0] snd_rsp_din,
    input  logic             main_rsp_rd,
    output logic [CMD_W-1:0] main_rsp_dout,
    output logic             rsp_valid
);

    localparam logic [NMI_CNT_W-1:0] NMI_LOAD = NMI_CNT_W'(NMI_CYCLES - 1);

    logic                 tick_c;
    logic                 irq_wrap_c;
    nmi_state_t           nmi_state;
    logic [NMI_CNT_W-1:0] nmi_cnt;

    assign tick_c = cen_snd & ~pause;

    // Command latch; a write always wins over a simultaneous read
    always_ff @(posedge clk_49m) begin
        if (reset) begin
            snd_cmd_dout <= '0;
            cmd_pending  <= 1'b0;
            cmd_overrun  <= 1'b0;
        end else if (main_cmd_wr) begin
            snd_cmd_dout <= main_cmd_din;
            cmd_pending  <= 1'b1;
            // Overwriting an unread command is only an overrun if it is not
            // being read in the same cycle
            if (cmd_pending && !snd_cmd_rd) begin
                cmd_overrun <= 1'b1;
            end
        end else if (snd_cmd_rd) begin
            cmd_pending <= 1'b0;
        end
    end

    // NMI handshake: one fixed-length pulse per command, then wait for the read
    always_ff @(posedge clk_49m) begin
        if (reset) begin
            nmi_state <= IDLE;
            nmi_cnt   <= '0;
            snd_nmi_n <= 1'b1;
        end else begin
            case (nmi_state)
                IDLE: begin
                    if (main_cmd_wr) begin
                        nmi_state <= ASSERT;
                        nmi_cnt   <= NMI_LOAD;
                        snd_nmi_n <= 1'b0;
                    end
                end
                ASSERT: begin
                    // Further writes here do not restart the pulse
                    if (tick_c) begin
                        if (nmi_cnt == '0) begin
                            nmi_state <= WAIT_RD;
                            snd_nmi_n <= 1'b1;
                        end else begin
                            nmi_cnt <= nmi_cnt - NMI_CNT_W'(1);
                        end
                    end
                end
                WAIT_RD: begin
                    if (!cmd_pending) begin
                        nmi_state <= IDLE;
                    end
                end
                default: begin
                    nmi_state <= IDLE;
                    snd_nmi_n <= 1'b1;
                end
            endcase
        end
    end

    bp_cen_period_timer #(
        .PERIOD (IRQ_PERIOD)
    ) u_irq_timer (
        .clk    (clk_49m),
        .reset  (reset),
        .tick   (tick_c),
        .wrap_c (irq_wrap_c)
    );

    // IRQ request: a new wrap beats a simultaneous acknowledge
    always_ff @(posedge clk_49m) begin
        if (reset) begin
            snd_irq_n <= 1'b1;
        end else if (irq_wrap_c) begin
            snd_irq_n <= 1'b0;
        end else if (snd_irq_ack) begin
            snd_irq_n <= 1'b1;
        end
    end

    // Response latch
    always_ff @(posedge clk_49m) begin
        if (reset) begin
            main_rsp_dout <= '0;
            rsp_valid     <= 1'b0;
        end else if (snd_rsp_wr) begin
            main_rsp_dout <= snd_rsp_din;
            rsp_valid     <= 1'b1;
        end else if (main_rsp_rd) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bp_sound_mailbox_ctrl.sv
// Directed self-checking bench for bp_sound_mailbox_ctrl.
// cen_snd runs every 4th clock; inputs are driven and outputs sampled
// 1 ns after each falling edge.
module tb_bp_sound_mailbox_ctrl;

    logic       clk_49m = 1'b0;
    logic       cen_snd = 1'b0;
    logic       reset;
    logic       pause;
    logic       main_cmd_wr;
    logic [7:0] main_cmd_din;
    logic       snd_cmd_rd;
    logic [7:0] snd_cmd_dout;
    logic       cmd_pending;
    logic       cmd_overrun;
    logic       snd_nmi_n;
    logic       snd_irq_n;
    logic       snd_irq_ack;
    logic       snd_rsp_wr;
    logic [7:0] snd_rsp_din;
    logic       main_rsp_rd;
    logic [7:0] main_rsp_dout;
    logic       rsp_valid;

    logic [1:0] cen_div = 2'd0;
    int clk_cnt       = 0;
    int nmi_low_clks  = 0;
    int nmi_low_ticks = 0;
    int n_checks      = 0;
    int n_fail        = 0;
    int f1_clk        = 0;

    bp_sound_mailbox_ctrl #(
        .IRQ_PERIOD (4096),
        .NMI_CYCLES (32)
    ) dut (
        .clk_49m       (clk_49m),
        .reset         (reset),
        .cen_snd       (cen_snd),
        .pause         (pause),
        .main_cmd_wr   (main_cmd_wr),
        .main_cmd_din  (main_cmd_din),
        .snd_cmd_rd    (snd_cmd_rd),
        .snd_cmd_dout  (snd_cmd_dout),
        .cmd_pending   (cmd_pending),
        .cmd_overrun   (cmd_overrun),
        .snd_nmi_n     (snd_nmi_n),
        .snd_irq_n     (snd_irq_n),
        .snd_irq_ack   (snd_irq_ack),
        .snd_rsp_wr    (snd_rsp_wr),
        .snd_rsp_din   (snd_rsp_din),
        .main_rsp_rd   (main_rsp_rd),
        .main_rsp_dout (main_rsp_dout),
        .rsp_valid     (rsp_valid)
    );

    always #5 clk_49m = ~clk_49m;

    // Clock-enable generator plus NMI low-time monitors. The tick chosen here
    // is seen at the next rising edge together with the current snd_nmi_n.
    always @(negedge clk_49m) begin
        clk_cnt = clk_cnt + 1;
        if (snd_nmi_n === 1'b0) nmi_low_clks = nmi_low_clks + 1;
        cen_div = (cen_div == 2'd3) ? 2'd0 : cen_div + 2'd1;
        cen_snd = (cen_div == 2'd0);
        if (cen_snd && snd_nmi_n === 1'b0) nmi_low_ticks = nmi_low_ticks + 1;
    end

    task automatic step();
        @(negedge clk_49m);
        #1;
    endtask

    // Next rising edge carries a cen_snd tick
    task automatic align_cen();
        do step(); while (!cen_snd);
    endtask

    task automatic wait_nmi_high(input string name);
        int i;
        i = 0;
        while (snd_nmi_n !== 1'b1 && i < 4000) begin step(); i++; end
        n_checks++;
        if (snd_nmi_n !== 1'b1) begin n_fail++; $display("FAIL %s_nmi_timeout: snd_nmi_n=%b after %0d clocks, want 1", name, snd_nmi_n, i); end
    endtask

    task automatic wait_irq_low(input string name);
        int i;
        i = 0;
        while (snd_irq_n !== 1'b0 && i < 20000) begin step(); i++; end
        n_checks++;
        if (snd_irq_n !== 1'b0) begin n_fail++; $display("FAIL %s_irq_timeout: snd_irq_n=%b after %0d clocks, want 0", name, snd_irq_n, i); end
    endtask

    task automatic test_reset();
        reset = 1'b1; pause = 1'b0;
        main_cmd_wr = 1'b0; main_cmd_din = 8'h00; snd_cmd_rd = 1'b0;
        snd_irq_ack = 1'b0; snd_rsp_wr = 1'b0; snd_rsp_din = 8'h00; main_rsp_rd = 1'b0;
        repeat (3) step();
        n_checks++; if (snd_cmd_dout !== 8'h00) begin n_fail++; $display("FAIL rst_cmd_dout: got %h want 00", snd_cmd_dout); end
        n_checks++; if (main_rsp_dout !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_dout: got %h want 00", main_rsp_dout); end
        n_checks++; if (cmd_pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending: got %b want 0", cmd_pending); end
        n_checks++; if (cmd_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b want 0", cmd_overrun); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (snd_nmi_n !== 1'b1) begin n_fail++; $display("FAIL rst_nmi_n: got %b want 1", snd_nmi_n); end
        n_checks++; if (snd_irq_n !== 1'b1) begin n_fail++; $display("FAIL rst_irq_n: got %b want 1", snd_irq_n); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_cmd_basic();
        int c0, t0;
        align_cen();
        c0 = nmi_low_clks; t0 = nmi_low_ticks;
        main_cmd_din = 8'h5A; main_cmd_wr = 1'b1; step(); main_cmd_wr = 1'b0;
        n_checks++; if (snd_cmd_dout !== 8'h5A) begin n_fail++; $display("FAIL basic_dout: got %h want 5a", snd_cmd_dout); end
        n_checks++; if (cmd_pending !== 1'b1) begin n_fail++; $display("FAIL basic_pending: got %b want 1", cmd_pending); end
        n_checks++; if (snd_nmi_n !== 1'b0) begin n_fail++; $display("FAIL basic_nmi_start: got %b want 0", snd_nmi_n); end
        wait_nmi_high("basic");
        // Write lands on a tick edge (ignored in IDLE); 32 more ticks, 4 clocks apart
        n_checks++; if (nmi_low_ticks - t0 != 32) begin n_fail++; $display("FAIL basic_nmi_ticks: got %0d want 32", nmi_low_ticks - t0); end
        n_checks++; if (nmi_low_clks - c0 != 128) begin n_fail++; $display("FAIL basic_nmi_clks: got %0d want 128", nmi_low_clks - c0); end
        n_checks++; if (cmd_pending !== 1'b1) begin n_fail++; $display("FAIL basic_pending_hold: got %b want 1", cmd_pending); end
        snd_cmd_rd = 1'b1; step(); snd_cmd_rd = 1'b0;
        n_checks++; if (cmd_pending !== 1'b0) begin n_fail++; $display("FAIL basic_read_clear: got %b want 0", cmd_pending); end
        n_checks++; if (snd_cmd_dout !== 8'h5A) begin n_fail++; $display("FAIL basic_dout_after_rd: got %h want 5a", snd_cmd_dout); end
    endtask

    task automatic test_overrun();
        int c0, c1;
        align_cen();
        c0 = nmi_low_clks;
        main_cmd_din = 8'h11; main_cmd_wr = 1'b1; step(); main_cmd_wr = 1'b0;
        n_checks++; if (snd_nmi_n !== 1'b0) begin n_fail++; $display("FAIL ovr_nmi_start: got %b want 0", snd_nmi_n); end
        step();
        main_cmd_din = 8'h33; main_cmd_wr = 1'b1; snd_cmd_rd = 1'b1; step();
        main_cmd_wr = 1'b0; snd_cmd_rd = 1'b0;
        n_checks++; if (snd_cmd_dout !== 8'h33) begin n_fail++; $display("FAIL coll_dout: got %h want 33", snd_cmd_dout); end
        n_checks++; if (cmd_pending !== 1'b1) begin n_fail++; $display("FAIL coll_pending: got %b want 1", cmd_pending); end
        n_checks++; if (cmd_overrun !== 1'b0) begin n_fail++; $display("FAIL coll_overrun: got %b want 0", cmd_overrun); end
        main_cmd_din = 8'h22; main_cmd_wr = 1'b1; step(); main_cmd_wr = 1'b0;
        n_checks++; if (snd_cmd_dout !== 8'h22) begin n_fail++; $display("FAIL ovr_dout: got %h want 22", snd_cmd_dout); end
        n_checks++; if (cmd_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", cmd_overrun); end
        wait_nmi_high("ovr");
        n_checks++; if (nmi_low_clks - c0 != 128) begin n_fail++; $display("FAIL ovr_single_pulse_clks: got %0d want 128", nmi_low_clks - c0); end
        // Pulse done, command unread: a new write must not retrigger
        c1 = nmi_low_clks;
        main_cmd_din = 8'h44; main_cmd_wr = 1'b1; step(); main_cmd_wr = 1'b0;
        repeat (16) step();
        n_checks++; if (nmi_low_clks - c1 != 0) begin n_fail++; $display("FAIL waitrd_no_retrigger: got %0d low clocks want 0", nmi_low_clks - c1); end
        n_checks++; if (snd_cmd_dout !== 8'h44) begin n_fail++; $display("FAIL waitrd_dout: got %h want 44", snd_cmd_dout); end
        snd_cmd_rd = 1'b1; step(); snd_cmd_rd = 1'b0;
        n_checks++; if (cmd_pending !== 1'b0) begin n_fail++; $display("FAIL ovr_read_clear: got %b want 0", cmd_pending); end
        n_checks++; if (cmd_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", cmd_overrun); end
    endtask

    task automatic test_rsp();
        snd_rsp_din = 8'hA5; snd_rsp_wr = 1'b1; step(); snd_rsp_wr = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rsp_valid_set: got %b want 1", rsp_valid); end
        n_checks++; if (main_rsp_dout !== 8'hA5) begin n_fail++; $display("FAIL rsp_dout: got %h want a5", main_rsp_dout); end
        main_rsp_rd = 1'b1; step(); main_rsp_rd = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_read_clear: got %b want 0", rsp_valid); end
        snd_rsp_din = 8'h3C; snd_rsp_wr = 1'b1; step();
        snd_rsp_din = 8'hC3; main_rsp_rd = 1'b1; step();
        snd_rsp_wr = 1'b0; main_rsp_rd = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rsp_coll_valid: got %b want 1", rsp_valid); end
        n_checks++; if (main_rsp_dout !== 8'hC3) begin n_fail++; $display("FAIL rsp_coll_dout: got %h want c3", main_rsp_dout); end
        main_rsp_rd = 1'b1; step(); main_rsp_rd = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_read_clear2: got %b want 0", rsp_valid); end
    endtask

    task automatic test_irq();
        wait_irq_low("irq_first");
        snd_irq_ack = 1'b1; step(); snd_irq_ack = 1'b0;
        n_checks++; if (snd_irq_n !== 1'b1) begin n_fail++; $display("FAIL irq_ack_clear: got %b want 1", snd_irq_n); end
        // Next wrap is 4096 ticks * 4 clocks after the first one
        repeat (16382) step();
        n_checks++; if (snd_irq_n !== 1'b1) begin n_fail++; $display("FAIL irq_no_early: got %b want 1", snd_irq_n); end
        snd_irq_ack = 1'b1; step(); snd_irq_ack = 1'b0;
        n_checks++; if (snd_irq_n !== 1'b0) begin n_fail++; $display("FAIL irq_wrap_ack_collision: got %b want 0", snd_irq_n); end
        f1_clk = clk_cnt;
        snd_irq_ack = 1'b1; step(); snd_irq_ack = 1'b0;
        n_checks++; if (snd_irq_n !== 1'b1) begin n_fail++; $display("FAIL irq_ack_clear2: got %b want 1", snd_irq_n); end
    endtask

    task automatic test_pause();
        int c0;
        align_cen();
        c0 = nmi_low_clks;
        main_cmd_din = 8'h77; main_cmd_wr = 1'b1; step(); main_cmd_wr = 1'b0;
        n_checks++; if (snd_nmi_n !== 1'b0) begin n_fail++; $display("FAIL pause_nmi_start: got %b want 0", snd_nmi_n); end
        repeat (19) step();
        pause = 1'b1; repeat (1000) step(); pause = 1'b0;
        n_checks++; if (snd_nmi_n !== 1'b0) begin n_fail++; $display("FAIL pause_not_cut: got %b want 0", snd_nmi_n); end
        wait_nmi_high("pause");
        n_checks++; if (nmi_low_clks - c0 != 1128) begin n_fail++; $display("FAIL pause_nmi_clks: got %0d want 1128", nmi_low_clks - c0); end
        snd_cmd_rd = 1'b1; step(); snd_cmd_rd = 1'b0;
        wait_irq_low("pause_irq");
        n_checks++; if (clk_cnt - f1_clk != 17384) begin n_fail++; $display("FAIL pause_irq_shift: got %0d clocks want 17384", clk_cnt - f1_clk); end
        snd_irq_ack = 1'b1; step(); snd_irq_ack = 1'b0;
        n_checks++; if (snd_irq_n !== 1'b1) begin n_fail++; $display("FAIL pause_irq_ack: got %b want 1", snd_irq_n); end
    endtask

    task automatic test_reset_mid_nmi();
        snd_rsp_din = 8'h77; snd_rsp_wr = 1'b1; step(); snd_rsp_wr = 1'b0;
        main_cmd_din = 8'hC4; main_cmd_wr = 1'b1; step(); main_cmd_wr = 1'b0;
        repeat (10) step();
        n_checks++; if (snd_nmi_n !== 1'b0) begin n_fail++; $display("FAIL rmid_nmi_low: got %b want 0", snd_nmi_n); end
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_rsp_valid: got %b want 1", rsp_valid); end
        reset = 1'b1; step(); reset = 1'b0;
        n_checks++; if (snd_nmi_n !== 1'b1) begin n_fail++; $display("FAIL rmid_nmi_n: got %b want 1", snd_nmi_n); end
        n_checks++; if (cmd_pending !== 1'b0) begin n_fail++; $display("FAIL rmid_pending: got %b want 0", cmd_pending); end
        n_checks++; if (cmd_overrun !== 1'b0) begin n_fail++; $display("FAIL rmid_overrun: got %b want 0", cmd_overrun); end
        n_checks++; if (snd_cmd_dout !== 8'h00) begin n_fail++; $display("FAIL rmid_cmd_dout: got %h want 00", snd_cmd_dout); end
        n_checks++; if (main_rsp_dout !== 8'h00) begin n_fail++; $display("FAIL rmid_rsp_dout: got %h want 00", main_rsp_dout); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp_valid_clr: got %b want 0", rsp_valid); end
        n_checks++; if (snd_irq_n !== 1'b1) begin n_fail++; $display("FAIL rmid_irq_n: got %b want 1", snd_irq_n); end
        repeat (200) step();
        n_checks++; if (snd_nmi_n !== 1'b1) begin n_fail++; $display("FAIL rmid_no_resume: got %b want 1", snd_nmi_n); end
    endtask

    initial begin
        test_reset();
        test_cmd_basic();
        test_overrun();
        test_rsp();
        test_irq();
        test_pause();
        test_reset_mid_nmi();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_sound_mailbox_ctrl.md
Name: bp_sound_mailbox_ctrl

Overview:
- Sequences the main-CPU to sound-CPU command path of the Blue Print core.
- Contents: an 8-bit command latch with NMI handshake, an 8-bit response latch read back by the main CPU, and the sound CPU's periodic IRQ scheduler.
- Sits between the main PCB and sound PCB inside the top level, replacing the ad-hoc cs_sounddata/irq_trigger wiring.
- All timing is counted in sound-CPU clock-enable ticks, so behaviour is identical under original and underclocked timings.

Parameters:
- IRQ_PERIOD, 4096: cen_snd ticks between sound-CPU IRQ requests. Legal range 2..65535.
- NMI_CYCLES, 32: cen_snd ticks that snd_nmi_n is held low per accepted command. Legal range 1..255.

Ports:
- clk_49m  in  1  system clock, 49.152 MHz
- reset  in  1  synchronous, active-high
- cen_snd  in  1  sound-CPU clock enable, one clk_49m cycle wide
- pause  in  1  freezes the IRQ counter and the NMI counter; latches stay writable
- main_cmd_wr  in  1  one-cycle strobe, main CPU writes the command
- main_cmd_din  in  8  command byte
- snd_cmd_rd  in  1  one-cycle strobe, sound CPU reads the command
- snd_cmd_dout  out  8  command latch contents
- cmd_pending  out  1  command written and not yet read
- cmd_overrun  out  1  sticky: a command was overwritten while pending
- snd_nmi_n  out  1  sound-CPU NMI, active low
- snd_irq_n  out  1  sound-CPU IRQ, active low
- snd_irq_ack  in  1  one-cycle strobe, sound-CPU interrupt acknowledge
- snd_rsp_wr  in  1  one-cycle strobe, sound CPU writes a response
- snd_rsp_din  in  8  response byte
- main_rsp_rd  in  1  one-cycle strobe, main CPU reads the response
- main_rsp_dout  out  8  response latch contents
- rsp_valid  out  1  response written and not yet read

Behaviour:
- Reset values (one clock after reset high; all registers clear synchronously):
  - snd_cmd_dout = 8'h00, main_rsp_dout = 8'h00
  - cmd_pending = 0, cmd_overrun = 0, rsp_valid = 0
  - snd_nmi_n = 1, snd_irq_n = 1
  - IRQ counter = 0, NMI FSM = IDLE
- Command latch:
  - main_cmd_wr loads main_cmd_din on the same edge; snd_cmd_dout is valid the next cycle.
  - cmd_pending sets on the same edge.
  - snd_cmd_rd clears cmd_pending.
  - main_cmd_wr and snd_cmd_rd in the same cycle: the write wins, the latch updates, cmd_pending stays 1, no overrun.
  - main_cmd_wr while cmd_pending=1 (no simultaneous read): the latch is overwritten and cmd_overrun sets. Only reset clears cmd_overrun.
- NMI FSM, states IDLE, ASSERT, WAIT_RD:
  - IDLE: on main_cmd_wr, go to ASSERT. snd_nmi_n goes 0 the next cycle and the NMI counter loads NMI_CYCLES-1.
  - ASSERT: on each cen_snd with pause=0, decrement the counter. When the counter is 0 and cen_snd=1, go to WAIT_RD and set snd_nmi_n = 1. Exactly NMI_CYCLES cen ticks of low are produced.
  - WAIT_RD: return to IDLE when cmd_pending=0. A main_cmd_wr in WAIT_RD does not retrigger the NMI; the overrun rule applies instead.
  - main_cmd_wr in ASSERT: the counter does not restart.
- IRQ scheduler:
  - 16-bit counter advances on cen_snd with pause=0 and wraps at IRQ_PERIOD-1 to 0.
  - On the wrap, snd_irq_n goes 0 the next cycle.
  - snd_irq_ack sets snd_irq_n = 1.
  - Wrap and ack in the same cycle: snd_irq_n remains 0 (new request wins).
  - Wrap while already asserted: stays asserted; there is no queueing.
- Response latch: mirror of the command latch. snd_rsp_wr sets rsp_valid and main_rsp_rd clears it; write wins on collision. No overrun flag and no interrupt.
- Reset asserted mid-NMI: snd_nmi_n returns to 1 on the next edge and any pending command is discarded.
- pause: counters hold. An in-progress NMI pulse is stretched, not cut.

Decomposition:
- Package bp_snd_pkg:
  - nmi_state_t enum {IDLE, ASSERT, WAIT_RD}
  - CMD_W = 8
  - IRQ_CNT_W = 16
  - NMI_CNT_W = 8
- One sub-module, bp_cen_period_timer (parameter PERIOD). Counts enabled ticks and emits a one-cycle wrap strobe. Used for the IRQ scheduler.
- The NMI counter stays inline.

Test Plan:
- Reset, then main_cmd_wr with 8'h5A. Required: snd_cmd_dout = 8'h5A and cmd_pending = 1 next cycle; snd_nmi_n low for exactly 32 cen_snd ticks; FSM in WAIT_RD. Then snd_cmd_rd → cmd_pending = 0, FSM IDLE.
- Write 8'h11, then 8'h22 before any read. Required: snd_cmd_dout = 8'h22, cmd_overrun = 1, only one NMI pulse. Simultaneous wr 8'h33 plus rd → pending stays 1, cmd_overrun unchanged.
- cen_snd every 4th clock with IRQ_PERIOD = 4096. Required: snd_irq_n falls every 16384 clocks. Ack clears it. Ack in the same cycle as a wrap leaves it low.
- pause = 1 for 1000 clocks during ASSERT. Required: NMI low time extended by exactly that interval; IRQ phase shifted by the same amount.
- snd_rsp_wr with 8'hA5. Required: rsp_valid = 1 and main_rsp_dout = 8'hA5. Then main_rsp_rd → rsp_valid = 0.
- Assert reset for one cycle in the middle of an NMI pulse. Required: snd_nmi_n = 1, cmd_pending = 0 and all outputs at reset values on the next edge.
